// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a conversion requester and bin2bcd_seq.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) ();
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to packed-BCD converter, one bit per clock.
module bin2bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  io
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [BW-1:0]     scr_q, scr_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BW-1:0]     adj;
    logic [BW-1:0]     scr_nxt;

    always_comb begin
        // Per-digit correction; each nibble is adjusted on its own, no carries.
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        scr_nxt = BW'({adj, work_q[WIDTH-1]});
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io.start) begin
                    state_d = SHIFT;
                    work_d  = io.bin;
                    scr_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                scr_d  = scr_nxt;
                work_d = {work_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = scr_nxt;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.bcd  = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq against a decimal reference model.
module tb_bin2bcd_seq;
    localparam int W = 32;
    localparam int D = 10;

    typedef struct {
        logic [4*D-1:0] bcd;
        int             due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

    bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   ndone  = 0;
    int   mon_bad;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4*D-1:0] ref_bcd(input logic [W-1:0] v);
        logic [4*D-1:0] r;
        longint unsigned x;
        r = '0;
        x = longint'(v);
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // The accepting edge is the next posedge; done is seen W posedges later.
    function automatic void push_exp(input logic [W-1:0] v);
        exp_t e;
        e.bcd = ref_bcd(v);
        e.due = cyc + 1 + W;
        sbq.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            check("done_width", {63'd0, done_prev}, 64'd0);
            check("sb_nonempty", {63'd0, sbq.size() != 0}, 64'd1);
            mon_bad = 0;
            for (int i = 0; i < D; i++)
                if (bus.bcd[4*i +: 4] > 4'd9) mon_bad++;
            check("digit_range", 64'(mon_bad), 64'd0);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                check("bcd", 64'(bus.bcd), 64'(mon_e.bcd));
                check("latency", 64'(cyc), 64'(mon_e.due));
                ndone++;
            end
        end
        done_prev <= bus.done && !rst;
    end

    task automatic issue(input logic [W-1:0] v);
        push_exp(v);
        bus.start = 1'b1;
        bus.bin   = v;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = $urandom;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) seen = bus.done;
        check({name, "_timeout"}, {63'd0, seen}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] vals[3] = '{32'd255, 32'hFFFF_FFFF, 32'd99999};
    int n;
    logic [W-1:0] v;

    initial begin
        bus.start = 1'b0;
        bus.bin   = '0;
        #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_bcd", 64'(bus.bcd), 64'd0);
        bus.start = 1'b1;
        bus.bin   = 32'd9;
        repeat (2) @(negedge clk);
        check("rst_ignore_start", {63'd0, bus.busy}, 64'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {63'd0, bus.busy}, 64'd0);

        issue('0);
        n = 0;
        for (int i = 0; i < W + 8 && bus.busy; i++) begin
            n++;
            @(negedge clk);
        end
        check("zero_busy_cycles", 64'(n), 64'(W));
        wait_done("zero");
        @(negedge clk);

        foreach (vals[i]) begin
            issue(vals[i]);
            wait_done("value");
            @(negedge clk);
        end

        // A second start four cycles into a conversion must be ignored.
        issue(32'd1234);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignored");
        @(negedge clk);

        bus.start = 1'b1;
        bus.bin   = 32'd10;
        push_exp(32'd10);
        @(negedge clk);
        wait_done("b2b1");
        push_exp(32'd20);
        bus.bin = 32'd20;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b2");
        @(negedge clk);

        issue(32'd500);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_done", {63'd0, bus.done}, 64'd0);
        check("midrst_bcd", 64'(bus.bcd), 64'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("midrst_bcd_hold", 64'(bus.bcd), 64'd0);
        issue(32'd42);
        wait_done("after_rst");
        @(negedge clk);

        for (int t = 0; t < 1000; t++) begin
            v = $urandom;
            issue(v);
            for (int k = 0; k < W + 8 && !bus.done; k++) begin
                bus.start = 1'($urandom % 2);
                bus.bin   = $urandom;
                @(negedge clk);
            end
            bus.start = 1'b0;
            check("rand_timeout", {63'd0, bus.done}, 64'd1);
            if ($urandom % 2 == 0) begin
                @(negedge clk);
                repeat ($urandom % 3) @(negedge clk);
            end
        end
        repeat (2) @(negedge clk);

        check("sb_empty", 64'(sbq.size()), 64'd0);
        check("done_count", 64'(ndone), 64'd1008);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
